// File: rtl/pwm_pkg.sv
// Shared constants and the per-pin drive function for the PWM output block.
// Optional duty shadowing is selected in pwm_peripheral by PWM_DUTY_SHADOW_EN.
package pwm_pkg;

  localparam int         PWM_STEPS   = 255;
  localparam logic [7:0] PWM_CNT_MAX = 8'(PWM_STEPS - 1);
  localparam int         NUM_PINS    = 16;
  localparam int         DUTY_W      = 8;

  // Disabled pins are forced low; enabled pins are static high unless in PWM mode.
  function automatic logic pin_drive(input logic en_out, input logic en_pwm, input logic pwm_sig);
    return en_out ? (en_pwm ? pwm_sig : 1'b1) : 1'b0;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Clock prescaler plus 0..254 PWM step counter; wrap flags the last clk of a period.
// Free-running, no backpressure; wrap is combinational from the registered counters.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              wrap
);

  // Keep at least one prescaler bit so CLK_DIV = 1 still elaborates cleanly.
  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              step;

  always_comb begin
    step    = (presc_q == PRESC_MAX);
    presc_d = step ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (step) begin
      cnt_d = (cnt_q == PWM_CNT_MAX) ? '0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pwm_cnt = cnt_q;
  assign wrap    = step && (cnt_q == PWM_CNT_MAX);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output stage fed by the SPI config registers; 1 clk register-to-pin latency.
// No backpressure. Define PWM_DUTY_SHADOW_EN to latch duty only at period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0]   pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_tick
);

  logic [DUTY_W-1:0]   pwm_cnt;
  logic                wrap;
  logic [DUTY_W-1:0]   duty_q;
  logic                pwm_sig;
  logic [NUM_PINS-1:0] en_out, en_pwm;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic                tick_q;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .wrap    (wrap)
  );

`ifdef PWM_DUTY_SHADOW_EN
  // Loading on the wrap clk makes the new duty apply from the next pwm_cnt = 0.
  logic [DUTY_W-1:0] duty_d;

  assign duty_d = wrap ? pwm_duty_cycle : duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end
`else
  assign duty_q = pwm_duty_cycle;
`endif

  // pwm_cnt tops out at 254, so duty 0xFF is always high and 0x00 never.
  assign pwm_sig = (pwm_cnt < duty_q);
  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      out_d[i] = pin_drive(en_out[i], en_pwm[i], pwm_sig);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      tick_q <= wrap;
    end
  end

  assign out         = out_q;
  assign period_tick = tick_q;

endmodule
